// File: rtl/tqvp_dlmiles_i2c_irqctl_if.sv
// Register-write bus for the I2C interrupt controller: one-cycle strobe, 2-bit select, 16-bit data.
interface tqvp_dlmiles_i2c_irqctl_if;
   logic        wr_en_i;
   logic [1:0]  wr_sel_i;
   logic [15:0] wr_data_i;

   modport master (output wr_en_i, output wr_sel_i, output wr_data_i);
   modport slave  (input  wr_en_i, input  wr_sel_i, input  wr_data_i);
endinterface

// File: rtl/tqvp_dlmiles_i2c_irqctl.sv
// Interrupt controller: sticky W1C status, mask, saturating event counter and IDLE/ACTIVE(/HOLDOFF) request FSM.
// Optional holdoff state enabled by defining TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN.
module tqvp_dlmiles_i2c_irqctl #(
   parameter int NSRC  = 4,
   parameter int CNT_W = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   tqvp_dlmiles_i2c_irqctl_if.slave     bus,
   input  logic [NSRC-1:0]              stb_event_i,
   output logic [NSRC-1:0]              status_o,
   output logic [NSRC-1:0]              mask_o,
   output logic [15:0]                  ctrl_o,
   output logic [CNT_W-1:0]             count_o,
   output logic                         interrupt_raw_o,
   output logic                         interrupt_o
);

`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLDOFF} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ACTIVE} state_t;
`endif

   state_t            r_state, w_state_nxt;
   logic [NSRC-1:0]   r_status, r_mask;
   logic              r_en, r_pulse, r_armed, r_irq;
   logic [CNT_W-1:0]  r_count;
   logic              w_wr_status, w_wr_mask, w_wr_ctrl, w_any_evt, w_eff;
   logic [NSRC-1:0]   w_clr;
   logic              w_unused;

   assign w_wr_status = bus.wr_en_i && (bus.wr_sel_i == 2'd0);
   assign w_wr_mask   = bus.wr_en_i && (bus.wr_sel_i == 2'd1);
   assign w_wr_ctrl   = bus.wr_en_i && (bus.wr_sel_i == 2'd2);
   assign w_clr       = w_wr_status ? bus.wr_data_i[NSRC-1:0] : '0;
   assign w_any_evt   = |stb_event_i;
   assign w_eff       = r_en & |(r_status & r_mask);
   assign w_unused    = &{1'b0, bus.wr_data_i};

   // Events are OR'd after the clear so a same-cycle event beats W1C
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_status <= '0;
         r_mask   <= '0;
         r_en     <= 1'b0;
         r_pulse  <= 1'b0;
         r_count  <= '0;
      end else begin
         r_status <= (r_status & ~w_clr) | stb_event_i;
         if (w_wr_mask) r_mask <= bus.wr_data_i[NSRC-1:0];
         if (w_wr_ctrl) begin
            r_en    <= bus.wr_data_i[0];
            r_pulse <= bus.wr_data_i[1];
         end
         if (w_wr_status)
            r_count <= {{(CNT_W-1){1'b0}}, w_any_evt};
         else if (w_any_evt && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + CNT_W'(1);
      end
   end

`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
   logic [7:0] r_ho_cfg, r_ho, w_ho_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ho_cfg <= 8'h00;
         r_ho     <= 8'h00;
      end else begin
         if (w_wr_ctrl) r_ho_cfg <= bus.wr_data_i[15:8];
         r_ho <= w_ho_nxt;
      end
   end

   assign ctrl_o = {r_ho_cfg, 6'b000000, r_pulse, r_en};
`else
   assign ctrl_o = {8'h00, 6'b000000, r_pulse, r_en};
`endif

   always_comb begin
      w_state_nxt = r_state;
`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
      w_ho_nxt    = r_ho;
`endif
      case (r_state)
         S_IDLE:
            if (w_eff && (r_armed || !r_pulse)) w_state_nxt = S_ACTIVE;
         S_ACTIVE:
            if (r_pulse || !w_eff) begin
`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
               if (r_ho_cfg != 8'h00) begin
                  w_state_nxt = S_HOLDOFF;
                  w_ho_nxt    = r_ho_cfg;
               end else begin
                  w_state_nxt = S_IDLE;
               end
`else
               w_state_nxt = S_IDLE;
`endif
            end
`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
         S_HOLDOFF: begin
            w_ho_nxt = (r_ho != 8'h00) ? r_ho - 8'd1 : 8'h00;
            if (r_ho <= 8'd1) w_state_nxt = S_IDLE;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
      if (!r_en) begin
         w_state_nxt = S_IDLE;
`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
         w_ho_nxt    = 8'h00;
`endif
      end
   end

   // Pulse mode re-arms only after eff has been seen low while idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_irq   <= 1'b0;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_irq   <= (w_state_nxt == S_ACTIVE);
         if (r_state == S_IDLE) begin
            if (!w_eff)       r_armed <= 1'b1;
            else if (r_pulse) r_armed <= 1'b0;
         end
      end
   end

   assign status_o        = r_status;
   assign mask_o          = r_mask;
   assign count_o         = r_count;
   assign interrupt_raw_o = |r_status;
   assign interrupt_o     = r_irq;

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_irqctl.sv
// Self-checking bench for tqvp_dlmiles_i2c_irqctl: directed scenarios plus random traffic against a reference model.
module tb_tqvp_dlmiles_i2c_irqctl;
   localparam int NSRC  = 4;
   localparam int CNT_W = 4;
`ifdef TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [NSRC-1:0]  stb_event_i;
   logic [NSRC-1:0]  status_o, mask_o;
   logic [15:0]      ctrl_o;
   logic [CNT_W-1:0] count_o;
   logic             interrupt_raw_o, interrupt_o;

   tqvp_dlmiles_i2c_irqctl_if bus ();

   tqvp_dlmiles_i2c_irqctl #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus),
      .stb_event_i     (stb_event_i),
      .status_o        (status_o),
      .mask_o          (mask_o),
      .ctrl_o          (ctrl_o),
      .count_o         (count_o),
      .interrupt_raw_o (interrupt_raw_o),
      .interrupt_o     (interrupt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: irq level, remaining holdoff cycles, pulse re-arm flag
   logic [NSRC-1:0] m_status, m_mask;
   bit              m_en, m_pulse, m_irq, m_armed;
   int              m_cnt, m_ho, m_hold;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_status = '0; m_mask = '0; m_en = 0; m_pulse = 0; m_irq = 0;
      m_armed = 1; m_cnt = 0; m_ho = 0; m_hold = 0;
   endtask

   task automatic model_clock(input bit rst, input bit we, input logic [1:0] sel,
                              input logic [15:0] d, input logic [NSRC-1:0] stb);
      bit eff, idle, n_irq, n_armed;
      int n_hold;
      logic [NSRC-1:0] clr;
      if (!rst) begin
         model_reset();
         return;
      end
      eff     = m_en && ((m_status & m_mask) != 0);
      idle    = !m_irq && (m_hold == 0);
      n_irq   = m_irq;
      n_hold  = m_hold;
      n_armed = m_armed;
      if (idle) begin
         if (!eff) n_armed = 1;
         else if (m_pulse) n_armed = 0;
      end
      if (!m_en) begin
         n_irq = 0; n_hold = 0;
      end else if (m_irq) begin
         if (m_pulse || !eff) begin
            n_irq  = 0;
            n_hold = HOLD_EN ? m_ho : 0;
         end
      end else if (m_hold > 0) begin
         n_hold = m_hold - 1;
      end else if (eff && (m_armed || !m_pulse)) begin
         n_irq = 1;
      end
      clr = (we && sel == 2'd0) ? d[NSRC-1:0] : '0;
      if (we && sel == 2'd0) m_cnt = (stb != 0) ? 1 : 0;
      else if (stb != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
      m_status = (m_status & ~clr) | stb;
      if (we && sel == 2'd1) m_mask = d[NSRC-1:0];
      if (we && sel == 2'd2) begin
         m_en = d[0]; m_pulse = d[1]; m_ho = HOLD_EN ? int'(d[15:8]) : 0;
      end
      m_irq = n_irq; m_hold = n_hold; m_armed = n_armed;
   endtask

   task automatic compare_all();
      chk("status", 32'(status_o), 32'(m_status));
      chk("mask",   32'(mask_o),   32'(m_mask));
      chk("ctrl",   32'(ctrl_o),   {16'h0, (HOLD_EN ? m_ho[7:0] : 8'h00), 6'b0, m_pulse, m_en});
      chk("count",  32'(count_o),  32'(m_cnt));
      chk("raw",    32'(interrupt_raw_o), 32'(m_status != 0));
      chk("irq",    32'(interrupt_o), 32'(m_irq));
   endtask

   task automatic step(input bit rst, input bit we, input logic [1:0] sel,
                       input logic [15:0] d, input logic [NSRC-1:0] stb);
      rst_n = rst; bus.wr_en_i = we; bus.wr_sel_i = sel; bus.wr_data_i = d; stb_event_i = stb;
      @(posedge clk);
      model_clock(rst, we, sel, d, stb);
      #1;
      compare_all();
      rst_n = 1'b1; bus.wr_en_i = 1'b0; bus.wr_sel_i = 2'd3; bus.wr_data_i = 16'h0; stb_event_i = '0;
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 2'd3, 16'h0, '0);
   endtask

   initial begin
      int pulses, k;
      bit we;
      logic [15:0] d;
      logic [NSRC-1:0] stb;
      rst_n = 1'b0; bus.wr_en_i = 1'b0; bus.wr_sel_i = 2'd0; bus.wr_data_i = 16'h0; stb_event_i = '0;
      model_reset();

      // reset with events and writes present
      step(1'b0, 1'b1, 2'd1, 16'hFFFF, 4'hF);
      step(1'b0, 1'b1, 2'd2, 16'hFFFF, 4'hA);
      chk("rst_status", 32'(status_o), 32'h0);
      chk("rst_irq", 32'(interrupt_o), 32'h0);

      // basic level interrupt
      step(1'b1, 1'b1, 2'd1, 16'h000F, '0);
      step(1'b1, 1'b1, 2'd2, 16'h0001, '0);
      step(1'b1, 1'b0, 2'd3, 16'h0, 4'h2);
      chk("evt_status_n1", 32'(status_o), 32'h2);
      chk("evt_irq_n1", 32'(interrupt_o), 32'h0);
      idle_step();
      chk("evt_irq_n2", 32'(interrupt_o), 32'h1);
      chk("evt_count", 32'(count_o), 32'h1);

      // W1C race and plain clear; sel=3 write ignored
      step(1'b1, 1'b1, 2'd0, 16'h0002, 4'h2);
      chk("w1c_race_status", 32'(status_o), 32'h2);
      chk("w1c_race_count", 32'(count_o), 32'h1);
      step(1'b1, 1'b1, 2'd3, 16'hFFFF, '0);
      step(1'b1, 1'b1, 2'd0, 16'h0002, '0);
      chk("w1c_status", 32'(status_o), 32'h0);
      idle_step();
      chk("w1c_irq", 32'(interrupt_o), 32'h0);

      // counter saturation
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'd3, 16'h0, 4'h3);
      chk("cnt_sat", 32'(count_o), 32'hF);

      // pulse mode
      step(1'b1, 1'b1, 2'd0, 16'h000F, '0);
      step(1'b1, 1'b1, 2'd2, 16'h0003, '0);
      pulses = 0;
      step(1'b1, 1'b0, 2'd3, 16'h0, 4'h1);
      pulses += int'(interrupt_o);
      for (int i = 0; i < 10; i++) begin idle_step(); pulses += int'(interrupt_o); end
      chk("pulse1_cnt", 32'(pulses), 32'd1);
      step(1'b1, 1'b1, 2'd0, 16'h0001, '0);
      pulses = 0;
      step(1'b1, 1'b0, 2'd3, 16'h0, 4'h1);
      pulses += int'(interrupt_o);
      for (int i = 0; i < 10; i++) begin idle_step(); pulses += int'(interrupt_o); end
      chk("pulse2_cnt", 32'(pulses), 32'd1);

      // holdoff / reassert latency after W1C then immediate new event
      step(1'b1, 1'b1, 2'd2, 16'h0501, '0);
      idle_step();
      idle_step();
      chk("ho_level_irq", 32'(interrupt_o), 32'h1);
      step(1'b1, 1'b1, 2'd0, 16'h0001, '0);
      step(1'b1, 1'b0, 2'd3, 16'h0, 4'h1);
      k = 1;
      while (!interrupt_o && k < 40) begin idle_step(); k++; end
      chk("reassert_lat", 32'(k), HOLD_EN ? 32'd7 : 32'd2);

      // reset while active with all sources pending
      step(1'b1, 1'b1, 2'd2, 16'h0001, 4'hF);
      idle_step();
      idle_step();
      chk("pre_rst_irq", 32'(interrupt_o), 32'h1);
      step(1'b0, 1'b1, 2'd1, 16'h000F, 4'hF);
      chk("rst_act_status", 32'(status_o), 32'h0);
      chk("rst_act_irq", 32'(interrupt_o), 32'h0);
      chk("rst_act_count", 32'(count_o), 32'h0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         we = ($urandom_range(0, 3) == 0);
         d  = 16'($urandom);
         if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
         if ($urandom_range(0, 1) == 0) d[15:8] = 8'($urandom_range(0, 6));
         stb = ($urandom_range(0, 2) == 0) ? NSRC'($urandom) : '0;
         step(($urandom_range(0, 63) != 0), we, 2'($urandom_range(0, 3)), d, stb);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/tqvp_dlmiles_i2c_irqctl.md
TQVP_DLMILES_I2C_IRQCTL -- requirements
Module: tqvp_dlmiles_i2c_irqctl

Interface
REQ-001 SHALL provide parameter NSRC, default 4, number of event sources (1..8).
REQ-002 SHALL provide parameter CNT_W, default 4, width of the event counter.
REQ-003 SHALL provide clk  input  1  clock.
REQ-004 SHALL provide rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide wr_en_i  input  1  register write strobe, one cycle.
REQ-006 SHALL provide wr_sel_i  input  2  register select: 0=STATUS (W1C), 1=MASK, 2=CTRL, 3=ignored.
REQ-007 SHALL provide wr_data_i  input  16  write data.
REQ-008 SHALL provide stb_event_i  input  NSRC  per-source single-cycle event pulses.
REQ-009 SHALL provide status_o  output  NSRC  sticky pending flags.
REQ-010 SHALL provide mask_o  output  NSRC  per-source enable mask.
REQ-011 SHALL provide ctrl_o  output  16  CTRL readback: bit0 EN, bit1 PULSE, bits15:8 HOLDOFF, others 0.
REQ-012 SHALL provide count_o  output  CNT_W  saturating event-cycle count.
REQ-013 SHALL provide interrupt_raw_o  output  1  OR of status_o, unmasked and ungated.
REQ-014 SHALL provide interrupt_o  output  1  registered interrupt request.

Function
REQ-015 Event on bit i at cycle N SHALL set status_o[i] visible at N+1; bit stays set until W1C.
REQ-016 STATUS write SHALL clear each bit whose wr_data_i bit is 1; an event on the same bit in the same cycle SHALL win (bit remains 1).
REQ-017 MASK/CTRL writes SHALL take effect the next cycle; writes with wr_sel_i=3 SHALL change nothing.
REQ-018 count_o SHALL increment by 1 per cycle with any stb_event_i bit high (not popcount) and saturate at 2^CNT_W-1.
REQ-019 Any STATUS write SHALL zero count_o; a same-cycle event SHALL yield count_o=1.
REQ-020 eff = EN & |(status_o & mask_o); interrupt_o SHALL be driven by FSM states IDLE, ACTIVE, HOLDOFF.
REQ-021 IDLE: interrupt_o=0; eff=1 -> ACTIVE; event at N with mask and EN set SHALL assert interrupt_o at N+2.
REQ-022 ACTIVE, PULSE=0: interrupt_o=1 while eff=1; eff=0 -> HOLDOFF (or IDLE per Configuration), interrupt_o=0 the next cycle.
REQ-023 ACTIVE, PULSE=1: interrupt_o=1 for exactly one cycle, then leave ACTIVE whatever eff is; no further pulse until eff has been 0 for at least one cycle in IDLE.
REQ-024 Clearing EN in any state SHALL force IDLE and interrupt_o=0 the next cycle; status_o and count_o SHALL be unaffected.
REQ-025 interrupt_raw_o SHALL be combinational |status_o, independent of mask, EN and FSM.

Reset
REQ-026 rst_n low at a clock edge SHALL set status_o=0, mask_o=0, ctrl_o=0, count_o=0, FSM=IDLE, holdoff counter=0, interrupt_o=0.
REQ-027 Reset SHALL take priority over writes and events in the same cycle, including mid-ACTIVE or mid-HOLDOFF.

Configuration
REQ-028 Macro TQVP_DLMILES_I2C_IRQ_HOLDOFF_EN defined: on leaving ACTIVE, load an 8-bit counter with CTRL[15:8] and enter HOLDOFF; interrupt_o=0; decrement each cycle; at 0 -> IDLE; HOLDOFF=0 -> IDLE directly.
REQ-029 Macro undefined: no HOLDOFF state or counter; ACTIVE -> IDLE directly; CTRL[15:8] not stored and read as 0.

Verification
REQ-030 Reset, MASK=0xF, CTRL=0x0001, pulse stb_event_i=0x2 at N -> status_o=0x2 at N+1, interrupt_o=1 at N+2, count_o=1.
REQ-031 STATUS W1C 0x2 with same-cycle stb_event_i=0x2 -> status_o stays 0x2, count_o=1; W1C 0x2 alone -> status_o=0, interrupt_o=0 next cycle.
REQ-032 CNT_W=4, 20 consecutive event cycles with stb_event_i=0x3 -> count_o=15 (saturated), not 40.
REQ-033 CTRL=0x0003 (PULSE), event held pending for 10 cycles -> interrupt_o high for exactly one cycle; W1C then new event -> second one-cycle pulse.
REQ-034 Macro defined, CTRL=0x0501, level interrupt then W1C, new event immediately -> interrupt_o low for 5 holdoff cycles, then reasserts; macro undefined -> reasserts at +2 cycles.
REQ-035 Assert rst_n low while ACTIVE with status_o=0xF -> all outputs 0 next cycle; events during reset ignored.
